// File: rtl/wbram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wbram_pkg: controller state encoding and ping-pong buffer pointer helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package wbram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_WRITE    = 2'd2,
    ST_PUBLISH  = 2'd3
  } wbram_state_e;

  // Bit 0 selects the BRAM half, bit 1 is the lap; same half on a different lap means the writer is two ahead.
  function automatic logic ptr_full(input logic [1:0] wr_ptr, input logic [1:0] rd_ptr);
    return (wr_ptr[0] == rd_ptr[0]) && (wr_ptr[1] != rd_ptr[1]);
  endfunction

  function automatic logic ptr_empty(input logic [1:0] wr_ptr, input logic [1:0] rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbram_wr_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wbram_wr_addr_gen: bank/word counters, registered one-hot bank write, overflow drop
// Rev 1.0
// ----------------------------------------------------------------------------
module wbram_wr_addr_gen #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int WBRAM_DEPTH  = 1800,
  parameter int ADDR_W       = $clog2(WBRAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    beat_accept,
  input  logic                    beat_last,
  input  logic [STREAM_WIDTH-1:0] beat_data,
  input  logic                    region_sel,
  output logic [ADDR_W-1:0]       addr,
  output logic [STREAM_WIDTH-1:0] data,
  output logic [NUM_BANKS-1:0]    ena,
  output logic                    drop
);

  localparam int HALF   = WBRAM_DEPTH / 2;
  localparam int WORD_W = $clog2(HALF + 1);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [BANK_W-1:0]       bank_q, bank_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [NUM_BANKS-1:0]    ena_q, ena_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [STREAM_WIDTH-1:0] data_q, data_d;
  logic                    word_full;

  // The word counter saturates at the half-depth so excess beats keep being dropped.
  assign word_full = (word_q == WORD_W'(HALF));

  always_comb begin
    bank_d = bank_q;
    word_d = word_q;
    ena_d  = '0;
    addr_d = addr_q;
    data_d = data_q;
    drop   = 1'b0;
    if (beat_accept) begin
      if (word_full) begin
        drop = 1'b1;
      end else begin
        ena_d  = NUM_BANKS'(1) << bank_q;
        addr_d = (region_sel ? ADDR_W'(HALF) : ADDR_W'(0)) + ADDR_W'(word_q);
        data_d = beat_data;
        if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
          bank_d = '0;
          word_d = word_q + WORD_W'(1);
        end else begin
          bank_d = bank_q + BANK_W'(1);
        end
      end
      if (beat_last) begin
        bank_d = '0;
        word_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= '0;
      word_q <= '0;
      ena_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      bank_q <= bank_d;
      word_q <= word_d;
      ena_q  <= ena_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign addr = addr_q;
  assign data = data_q;
  assign ena  = ena_q;

endmodule
`default_nettype wire

// File: rtl/wbram_controller_wr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wbram_controller_wr: streams layer weights into ping-pong halves of the banked BRAM
// and publishes each filled half to the reader. Rev 1.0
// ----------------------------------------------------------------------------
module wbram_controller_wr
  import wbram_pkg::*;
#(
  parameter int STREAM_WIDTH   = 128,
  parameter int NUM_BANKS      = 16,
  parameter int WBRAM_DEPTH    = 1800,
  parameter int MAX_NUM_LAYERS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(MAX_NUM_LAYERS):0]  num_layers,
  input  logic [STREAM_WIDTH-1:0]          s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [$clog2(WBRAM_DEPTH)-1:0]   addrA,
  output logic [STREAM_WIDTH-1:0]          doA,
  output logic [NUM_BANKS-1:0]             enaA,
  output logic [NUM_BANKS-1:0]             weA,
  output logic [1:0]                       wr_pointer_data_r,
  output logic                             wr_pointer_valid_r,
  input  logic                             wr_pointer_ready_r,
  input  logic [1:0]                       rd_pointer_data_r,
  input  logic                             rd_pointer_valid_r,
  output logic                             rd_pointer_ready_r,
  output logic                             done,
  output logic                             overflow
);

  localparam int NL_W = $clog2(MAX_NUM_LAYERS) + 1;

  wbram_state_e         state_q, state_d;
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [NL_W-1:0]      layer_count_q, layer_count_d;
  logic [NL_W-1:0]      num_layers_q, num_layers_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic                 rd_ready_q;
  logic                 beat_accept;
  logic                 buf_full;
  logic                 beat_drop;
  logic [NUM_BANKS-1:0] bank_ena;

  assign beat_accept = s_axis_tvalid & s_axis_tready;
  assign buf_full    = ptr_full(wr_ptr_q, rd_ptr_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      layer_count_q <= '0;
      num_layers_q  <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      rd_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      layer_count_q <= layer_count_d;
      num_layers_q  <= num_layers_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      rd_ready_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_pointer_valid_r ? rd_pointer_data_r : rd_ptr_q;
    layer_count_d = layer_count_q;
    num_layers_d  = num_layers_q;
    done_d        = 1'b0;
    overflow_d    = overflow_q | beat_drop;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_layers != '0) begin
            state_d       = ST_WAIT_BUF;
            layer_count_d = '0;
            num_layers_d  = num_layers;
            overflow_d    = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_WAIT_BUF: begin
        if (!buf_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (beat_accept && s_axis_tlast) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        if (wr_pointer_ready_r) begin
          wr_ptr_d = wr_ptr_q + 2'd1;
          if (layer_count_q == num_layers_q - NL_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            layer_count_d = layer_count_q + NL_W'(1);
            state_d       = ST_WAIT_BUF;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer data is only meaningful while valid; it reads as zero otherwise.
  always_comb begin
    s_axis_tready      = (state_q == ST_WRITE);
    wr_pointer_valid_r = (state_q == ST_PUBLISH);
    wr_pointer_data_r  = wr_pointer_valid_r ? (wr_ptr_q + 2'd1) : 2'd0;
  end

  wbram_wr_addr_gen #(
    .STREAM_WIDTH (STREAM_WIDTH),
    .NUM_BANKS    (NUM_BANKS),
    .WBRAM_DEPTH  (WBRAM_DEPTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_accept (beat_accept),
    .beat_last   (s_axis_tlast),
    .beat_data   (s_axis_tdata),
    .region_sel  (wr_ptr_q[0]),
    .addr        (addrA),
    .data        (doA),
    .ena         (bank_ena),
    .drop        (beat_drop)
  );

  assign enaA               = bank_ena;
  assign weA                = bank_ena;
  assign rd_pointer_ready_r = rd_ready_q;
  assign done               = done_q;
  assign overflow           = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_wbram_controller_wr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wbram_controller_wr: directed scenarios plus randomized runs against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wbram_controller_wr;

  localparam int SW   = 128;
  localparam int NB   = 16;
  localparam int DEP  = 1800;
  localparam int HALF = DEP / 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_WRITE = 2, P_PUB = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      num_layers = '0;
  logic [SW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic            s_axis_tlast = 1'b0;
  logic [10:0]     addrA;
  logic [SW-1:0]   doA;
  logic [NB-1:0]   enaA, weA;
  logic [1:0]      wr_pointer_data_r;
  logic            wr_pointer_valid_r;
  logic            wr_pointer_ready_r = 1'b0;
  logic [1:0]      rd_pointer_data_r = '0;
  logic            rd_pointer_valid_r = 1'b0;
  logic            rd_pointer_ready_r;
  logic            done, overflow;

  wbram_controller_wr #(
    .STREAM_WIDTH(SW), .NUM_BANKS(NB), .WBRAM_DEPTH(DEP), .MAX_NUM_LAYERS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .addrA(addrA), .doA(doA), .enaA(enaA), .weA(weA),
    .wr_pointer_data_r(wr_pointer_data_r), .wr_pointer_valid_r(wr_pointer_valid_r),
    .wr_pointer_ready_r(wr_pointer_ready_r), .rd_pointer_data_r(rd_pointer_data_r),
    .rd_pointer_valid_r(rd_pointer_valid_r), .rd_pointer_ready_r(rd_pointer_ready_r),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int         m_phase = P_IDLE, m_beat = 0, m_layer = 0, m_nl = 0;
  logic [1:0] m_wr = '0, m_rd = '0;
  logic       m_ovf = 1'b0, chk_en = 1'b0;
  logic       e_tready = 0, e_valid = 0, e_done = 0, e_rdy = 0, e_addr_chk = 0;
  logic [1:0] e_pdata = '0;
  logic [NB-1:0] e_ena = '0;
  logic [10:0]   e_addr = '0;
  logic [SW-1:0] e_do = '0;

  // Snapshots and logs of what the DUT did
  logic          s_tready, s_valid, s_done, s_ovf, s_rdy;
  logic [1:0]    s_pdata;
  logic [NB-1:0] s_ena;
  logic [10:0]   s_addr;
  logic [SW-1:0] s_do;
  logic          last_acc = 1'b0;
  int            wr_cnt = 0, done_cnt = 0;
  logic [10:0]   first_addr, last_addr;
  logic [NB-1:0] first_ena, last_ena;
  logic [1:0]    dut_pubs[$];
  logic [1:0]    rd_q[$];
  bit            rand_ready = 0, rand_rd = 0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advances on each clock edge from the rules: states, pointer distance, bank/word arithmetic.
  task automatic model_update();
    int nxt, word, bank;
    logic [1:0] gap;
    e_ena = '0; e_done = 1'b0; e_addr_chk = 1'b0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_wr = '0; m_rd = '0; m_beat = 0; m_layer = 0; m_ovf = 1'b0;
      e_addr = '0; e_do = '0; e_addr_chk = 1'b1; e_rdy = 1'b0; chk_en = 1'b1;
    end else begin
      e_rdy = 1'b1;
      nxt = m_phase;
      gap = m_wr - m_rd;
      case (m_phase)
        P_IDLE: if (start) begin
          if (num_layers != 0) begin
            nxt = P_WAIT; m_layer = 0; m_nl = int'(num_layers); m_ovf = 1'b0;
          end else e_done = 1'b1;
        end
        P_WAIT: if (gap != 2'd2) nxt = P_WRITE;
        P_WRITE: if (s_axis_tvalid) begin
          word = m_beat / NB;
          bank = m_beat % NB;
          if (word < HALF) begin
            e_ena = NB'(1) << bank;
            e_addr = 11'((m_wr[0] ? HALF : 0) + word);
            e_do = s_axis_tdata;
            e_addr_chk = 1'b1;
          end else m_ovf = 1'b1;
          m_beat++;
          if (s_axis_tlast) begin m_beat = 0; nxt = P_PUB; end
        end
        default: if (wr_pointer_ready_r) begin
          m_wr = m_wr + 2'd1;
          if (m_layer == m_nl - 1) begin nxt = P_IDLE; e_done = 1'b1; end
          else begin m_layer++; nxt = P_WAIT; end
        end
      endcase
      if (rd_pointer_valid_r) m_rd = rd_pointer_data_r;
      m_phase = nxt;
    end
    e_tready = (m_phase == P_WRITE);
    e_valid  = (m_phase == P_PUB);
    e_pdata  = e_valid ? m_wr + 2'd1 : 2'd0;
  endtask

  // One clock: compare at the falling edge, update the model at the rising edge, then drive.
  task automatic step();
    @(negedge clk);
    s_tready = s_axis_tready; s_valid = wr_pointer_valid_r; s_done = done; s_ovf = overflow;
    s_rdy = rd_pointer_ready_r; s_pdata = wr_pointer_data_r; s_ena = enaA; s_addr = addrA; s_do = doA;
    if (chk_en) begin
      check("tready", s_tready, e_tready);
      check("enaA", s_ena, e_ena);
      check("weA", weA, e_ena);
      check("wr_ptr_valid", s_valid, e_valid);
      check("wr_ptr_data", s_pdata, e_pdata);
      check("done", s_done, e_done);
      check("overflow", s_ovf, m_ovf);
      check("rd_ptr_ready", s_rdy, e_rdy);
      if (e_addr_chk) begin
        check("addrA", s_addr, e_addr);
        check("doA", s_do, e_do);
      end
    end
    if (s_ena != '0) begin
      if (wr_cnt == 0) begin first_addr = s_addr; first_ena = s_ena; end
      wr_cnt++; last_addr = s_addr; last_ena = s_ena;
    end
    if (s_valid && wr_pointer_ready_r) begin
      dut_pubs.push_back(s_pdata);
      if (rand_rd) rd_q.push_back(s_pdata);
    end
    if (s_done) done_cnt++;
    last_acc = s_axis_tvalid && s_tready;
    @(posedge clk);
    model_update();
    #1;
    if (rand_ready) wr_pointer_ready_r = 1'($urandom_range(1));
    if (rand_rd) begin
      if (rd_q.size() > 0 && $urandom_range(3) == 0) begin
        rd_pointer_valid_r = 1'b1; rd_pointer_data_r = rd_q.pop_front();
      end else rd_pointer_valid_r = 1'b0;
    end
  endtask

  task automatic clear_logs();
    wr_cnt = 0; done_cnt = 0; dut_pubs.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rd_pointer_valid_r = 1'b0; wr_pointer_ready_r = 1'b0; rd_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic start_run(input int nl);
    start = 1'b1; num_layers = 3'(nl);
    step();
    start = 1'b0;
  endtask

  task automatic send_layer(input int n, input int pct, input bit with_last, input bit noise);
    int k = 0, cyc = 0;
    while (k < n && cyc < n * 20 + 200) begin
      s_axis_tvalid = ($urandom_range(99) < pct);
      s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = with_last && (k == n - 1);
      if (noise) begin start = ($urandom_range(7) == 0); num_layers = 3'($urandom_range(7)); end
      step();
      if (last_acc) k++;
      cyc++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; start = 1'b0;
    check("layer_beats_accepted", k, n);
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (s_done) begin seen = 1; break; end
    end
    check("done_seen", 128'(seen), 128'(1));
  endtask

  initial begin
    // reset values
    step(); step();
    check("rst_tready", s_tready, 0);
    check("rst_addrA", s_addr, 0);
    check("rst_rd_ready", s_rdy, 0);
    rst_n = 1'b1;
    step(); step();
    check("rd_ready_after_rst", s_rdy, 1);
    clear_logs();

    // zero-layer run: done one cycle after start, nothing written or published
    start_run(0);
    step();
    check("nl0_done_next", s_done, 1);
    repeat (4) step();
    check("nl0_writes", wr_cnt, 0);
    check("nl0_pubs", dut_pubs.size(), 0);
    check("nl0_done_cnt", done_cnt, 1);

    // single layer of 32 beats
    clear_logs();
    wr_pointer_ready_r = 1'b1;
    start_run(1);
    send_layer(32, 100, 1, 0);
    wait_done(50);
    check("l32_writes", wr_cnt, 32);
    check("l32_first_addr", first_addr, 0);
    check("l32_first_ena", first_ena, 16'h0001);
    check("l32_last_addr", last_addr, 1);
    check("l32_last_ena", last_ena, 16'h8000);
    check("l32_pub_cnt", dut_pubs.size(), 1);
    if (dut_pubs.size() > 0) check("l32_pub_val", dut_pubs[0], 1);

    // publish held off by the reader for 10 cycles
    do_reset();
    start_run(1);
    send_layer(16, 100, 1, 0);
    for (int i = 0; i < 20; i++) begin step(); if (s_valid) break; end
    check("hold_valid_seen", s_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_valid", s_valid, 1);
      check("hold_data", s_pdata, 1);
      check("hold_tready", s_tready, 0);
    end
    wr_pointer_ready_r = 1'b1;
    wait_done(10);
    check("hold_pub_cnt", dut_pubs.size(), 1);

    // three layers with a silent reader: third layer waits for the freed half
    do_reset();
    wr_pointer_ready_r = 1'b1;
    start_run(3);
    send_layer(20, 100, 1, 0);
    send_layer(20, 100, 1, 0);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("stall_tready", s_tready, 0);
    end
    s_axis_tvalid = 1'b0;
    check("stall_pub_cnt", dut_pubs.size(), 2);
    if (dut_pubs.size() == 2) begin
      check("stall_pub0", dut_pubs[0], 1);
      check("stall_pub1", dut_pubs[1], 2);
    end
    clear_logs();
    rd_pointer_valid_r = 1'b1; rd_pointer_data_r = 2'd1;
    step();
    rd_pointer_valid_r = 1'b0;
    send_layer(20, 100, 1, 0);
    wait_done(20);
    check("l3_first_addr", first_addr, 0);
    check("l3_last_addr", last_addr, 1);
    if (dut_pubs.size() > 0) check("l3_pub", dut_pubs[0], 3);

    // reset in the middle of a layer
    do_reset();
    wr_pointer_ready_r = 1'b1;
    start_run(1);
    send_layer(5, 100, 0, 0);
    rst_n = 1'b0;
    step(); step();
    check("midrst_tready", s_tready, 0);
    check("midrst_ena", s_ena, 0);
    check("midrst_addr", s_addr, 0);
    check("midrst_do", s_do, 0);
    check("midrst_valid", s_valid, 0);
    check("midrst_pdata", s_pdata, 0);
    rst_n = 1'b1;
    step();
    clear_logs();
    start_run(1);
    send_layer(18, 100, 1, 0);
    wait_done(20);
    check("midrst_first_addr", first_addr, 0);
    check("midrst_first_ena", first_ena, 16'h0001);
    check("midrst_writes", wr_cnt, 18);
    if (dut_pubs.size() > 0) check("midrst_pub", dut_pubs[0], 1);

    // layer overruns its half by 3 beats
    do_reset();
    wr_pointer_ready_r = 1'b1;
    start_run(1);
    send_layer(NB * HALF + 3, 100, 1, 0);
    wait_done(20);
    check("ovf_writes", wr_cnt, NB * HALF);
    check("ovf_last_addr", last_addr, HALF - 1);
    check("ovf_flag", s_ovf, 1);
    check("ovf_pub_cnt", dut_pubs.size(), 1);

    // randomized runs with a random reader and random start noise outside IDLE
    do_reset();
    rand_ready = 1; rand_rd = 1;
    for (int r = 0; r < 10; r++) begin
      int nl;
      nl = $urandom_range(4);
      start_run(nl);
      for (int l = 0; l < nl; l++) send_layer($urandom_range(1, 40), 70, 1, 1);
      wait_done(500);
      repeat ($urandom_range(3)) step();
    end
    rand_ready = 0; rand_rd = 0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
